// File: rtl/playfield_renderer.sv
// Three-stage pixel pipeline for a 10x20 tile playfield with border, background
// and a frame-timed line-clear flash on a selectable set of playfield rows.
module playfield_renderer #(
  parameter int FLASH_PERIOD  = 4,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        pix_valid,
  input  logic [9:0]  vga_row,
  input  logic [9:0]  vga_col,
  input  logic        blank,
  input  logic        frame_start,
  input  logic        flash_start,
  input  logic [19:0] flash_rows,
  output logic        tile_rd_en,
  output logic [4:0]  tile_rd_row,
  output logic [3:0]  tile_rd_col,
  input  logic [3:0]  tile_rd_data,
  output logic [23:0] rgb_out,
  output logic        rgb_valid,
  output logic        flash_busy,
  output logic        flash_done
);

  typedef enum logic [3:0] {
    T_BLANK, T_GARBAGE, T_GHOST, T_I, T_O, T_T, T_J, T_L, T_S, T_Z
  } tile_type_t;

  typedef enum logic [1:0] {REG_BG, REG_BORDER, REG_PF} region_t;
  typedef enum logic [1:0] {F_IDLE, F_ON, F_OFF} flash_state_t;

  localparam int FCW = $clog2(FLASH_PERIOD + 1);
  localparam int PCW = $clog2(FLASH_TOGGLES + 1);

  flash_state_t   fstate;
  logic [FCW-1:0] frame_cnt;
  logic [PCW-1:0] phase_cnt;
  logic [19:0]    fmask;

  // Stage 1: classification and tile address
  logic       in_pf, in_bd, hit;
  logic [9:0] pf_row, pf_col;
  logic [4:0] trow;
  logic [3:0] tcol;
  region_t    region;

  always_comb begin
    in_pf  = (vga_col >= 10'd240) && (vga_col < 10'd400) &&
             (vga_row >= 10'd60)  && (vga_row < 10'd460);
    in_bd  = (vga_col >= 10'd235) && (vga_col < 10'd405) &&
             (vga_row >= 10'd55)  && (vga_row < 10'd465);
    pf_row = vga_row - 10'd60;
    pf_col = vga_col - 10'd240;
    trow   = 5'(pf_row / 10'd20);
    tcol   = 4'(pf_col >> 4);
    region = in_pf ? REG_PF : (in_bd ? REG_BORDER : REG_BG);
    // Flash decision is frozen here so a mid-pixel state change cannot split it
    hit    = in_pf && (fstate == F_ON) && (trow < 5'd20) && fmask[trow];
  end

  logic    s1_valid, s1_blank, s1_hit;
  region_t s1_region;
  logic    s2_valid, s2_blank, s2_hit;
  region_t s2_region;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      s1_valid    <= 1'b0;
      s1_blank    <= 1'b0;
      s1_hit      <= 1'b0;
      s1_region   <= REG_BG;
      tile_rd_en  <= 1'b0;
      tile_rd_row <= '0;
      tile_rd_col <= '0;
      s2_valid    <= 1'b0;
      s2_blank    <= 1'b0;
      s2_hit      <= 1'b0;
      s2_region   <= REG_BG;
    end else begin
      s1_valid    <= pix_valid;
      s1_blank    <= blank;
      s1_hit      <= pix_valid && hit;
      s1_region   <= region;
      tile_rd_en  <= pix_valid && in_pf;
      tile_rd_row <= (pix_valid && in_pf) ? trow : '0;
      tile_rd_col <= (pix_valid && in_pf) ? tcol : '0;
      s2_valid    <= s1_valid;
      s2_blank    <= s1_blank;
      s2_hit      <= s1_hit;
      s2_region   <= s1_region;
    end
  end

  // Stage 3: tile data arrives here, one cycle after the read request
  function automatic logic [23:0] tile_color(input logic [3:0] t);
    case (tile_type_t'(t))
      T_BLANK:   return 24'h000000;
      T_GARBAGE: return 24'haaaaaa;
      T_GHOST:   return 24'h808080;
      T_I:       return 24'h00fdff;
      T_O:       return 24'hffff00;
      T_T:       return 24'hff00ff;
      T_J:       return 24'h0000ff;
      T_L:       return 24'hff8000;
      T_S:       return 24'h00ff00;
      T_Z:       return 24'hff0000;
      default:   return 24'h000000;
    endcase
  endfunction

  logic [23:0] pix_rgb;

  always_comb begin
    pix_rgb = 24'h404040;
    if (s2_blank)
      pix_rgb = 24'h000000;
    else if (s2_region == REG_PF)
      pix_rgb = s2_hit ? 24'hffffff : tile_color(tile_rd_data);
    else if (s2_region == REG_BORDER)
      pix_rgb = 24'hffffff;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      rgb_out   <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_out   <= s2_valid ? pix_rgb : '0;
      rgb_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      fstate     <= F_IDLE;
      frame_cnt  <= '0;
      phase_cnt  <= '0;
      fmask      <= '0;
      flash_busy <= 1'b0;
      flash_done <= 1'b0;
    end else begin
      flash_done <= 1'b0;
      case (fstate)
        F_IDLE: begin
          // A coincident frame_start is deliberately not counted here
          if (flash_start) begin
            fmask      <= flash_rows;
            frame_cnt  <= '0;
            phase_cnt  <= '0;
            fstate     <= F_ON;
            flash_busy <= 1'b1;
          end
        end
        F_ON, F_OFF: begin
          if (frame_start) begin
            if (frame_cnt == FCW'(FLASH_PERIOD - 1)) begin
              frame_cnt <= '0;
              phase_cnt <= phase_cnt + PCW'(1);
              if (phase_cnt == PCW'(FLASH_TOGGLES - 1)) begin
                fstate     <= F_IDLE;
                flash_busy <= 1'b0;
                flash_done <= 1'b1;
              end else begin
                fstate <= (fstate == F_ON) ? F_OFF : F_ON;
              end
            end else begin
              frame_cnt <= frame_cnt + FCW'(1);
            end
          end
        end
        default: begin
          fstate     <= F_IDLE;
          flash_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_playfield_renderer.sv
// Directed and random-stream bench for playfield_renderer with a reference
// pixel/flash model and a tile RAM answering one cycle after each request.
module tb_playfield_renderer;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        pix_valid;
  logic [9:0]  vga_row, vga_col;
  logic        blank, frame_start, flash_start;
  logic [19:0] flash_rows;
  logic        tile_rd_en;
  logic [4:0]  tile_rd_row;
  logic [3:0]  tile_rd_col;
  logic [3:0]  tile_rd_data;
  logic [23:0] rgb_out;
  logic        rgb_valid, flash_busy, flash_done;

  always #5 clk = ~clk;

  playfield_renderer #(.FLASH_PERIOD(4), .FLASH_TOGGLES(6)) dut (
    .clk(clk), .rst_l(rst_l), .pix_valid(pix_valid), .vga_row(vga_row),
    .vga_col(vga_col), .blank(blank), .frame_start(frame_start),
    .flash_start(flash_start), .flash_rows(flash_rows),
    .tile_rd_en(tile_rd_en), .tile_rd_row(tile_rd_row),
    .tile_rd_col(tile_rd_col), .tile_rd_data(tile_rd_data),
    .rgb_out(rgb_out), .rgb_valid(rgb_valid), .flash_busy(flash_busy),
    .flash_done(flash_done)
  );

  logic [3:0] mem [20][10];

  always @(posedge clk)
    tile_rd_data <= (tile_rd_row < 5'd20 && tile_rd_col < 4'd10) ?
                    mem[tile_rd_row][tile_rd_col] : 4'h0;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [23:0] cmap [16] = '{24'h000000, 24'haaaaaa, 24'h808080, 24'h00fdff,
                             24'hffff00, 24'hff00ff, 24'h0000ff, 24'hff8000,
                             24'h00ff00, 24'hff0000, 24'h000000, 24'h000000,
                             24'h000000, 24'h000000, 24'h000000, 24'h000000};

  // Flash model: 0 idle, 1 on, 2 off
  int          m_st, m_fc, m_pc;
  logic [19:0] m_mask;
  logic        m_done;

  typedef struct {logic v; logic [23:0] rgb;} exp_t;
  exp_t q[$];

  function automatic logic is_pf(input int r, input int c);
    return (c >= 240 && c < 400 && r >= 60 && r < 460);
  endfunction

  function automatic exp_t ref_pixel(input logic pv, input int r, input int c, input logic bl);
    exp_t e;
    int tr, tc;
    e.v = pv;
    e.rgb = 24'h0;
    if (pv && !bl) begin
      if (is_pf(r, c)) begin
        tr = (r - 60) / 20;
        tc = (c - 240) / 16;
        e.rgb = (m_st == 1 && m_mask[tr]) ? 24'hffffff : cmap[mem[tr][tc]];
      end else if (c >= 235 && c < 405 && r >= 55 && r < 465)
        e.rgb = 24'hffffff;
      else
        e.rgb = 24'h404040;
    end
    return e;
  endfunction

  task automatic model_reset();
    m_st = 0; m_fc = 0; m_pc = 0; m_mask = '0; m_done = 1'b0;
    q.delete();
    q.push_back('{1'b0, 24'h0});
    q.push_back('{1'b0, 24'h0});
  endtask

  task automatic cycle(input logic pv, input int r, input int c, input logic bl,
                       input logic fs, input logic fls, input logic [19:0] rows);
    exp_t e;
    logic e_en;
    int e_r, e_c;
    pix_valid = pv; vga_row = 10'(r); vga_col = 10'(c); blank = bl;
    frame_start = fs; flash_start = fls; flash_rows = rows;
    q.push_back(ref_pixel(pv, r, c, bl));
    e_en = pv && is_pf(r, c);
    e_r = (r - 60) / 20;
    e_c = (c - 240) / 16;
    m_done = 1'b0;
    if (m_st == 0) begin
      if (fls) begin m_mask = rows; m_fc = 0; m_pc = 0; m_st = 1; end
    end else if (fs) begin
      if (m_fc + 1 == 4) begin
        m_fc = 0;
        m_pc++;
        if (m_pc == 6) begin m_st = 0; m_done = 1'b1; end
        else m_st = (m_st == 1) ? 2 : 1;
      end else m_fc++;
    end
    @(posedge clk); #1;
    check("rd_en", tile_rd_en, e_en);
    if (e_en) begin
      check("rd_row", tile_rd_row, e_r);
      check("rd_col", tile_rd_col, e_c);
    end
    if (q.size() == 3) begin
      e = q.pop_front();
      check("rgb_valid", rgb_valid, e.v);
      if (e.v) check("rgb", rgb_out, e.rgb);
    end
    check("flash_busy", flash_busy, m_st != 0);
    check("flash_done", flash_done, m_done);
    if (flash_done) done_seen++;
  endtask

  task automatic idle();
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 20'h0);
  endtask

  task automatic do_reset();
    rst_l = 1'b0; pix_valid = 1'b0; frame_start = 1'b0; flash_start = 1'b0;
    blank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rgb", rgb_out, 24'h0);
    check("rst_rgb_valid", rgb_valid, 1'b0);
    check("rst_rd_en", tile_rd_en, 1'b0);
    check("rst_rd_row", tile_rd_row, 5'd0);
    check("rst_rd_col", tile_rd_col, 4'd0);
    check("rst_busy", flash_busy, 1'b0);
    check("rst_done", flash_done, 1'b0);
    rst_l = 1'b1;
    model_reset();
  endtask

  // Pixel then two bubbles; the pixel's colour is on rgb_out after the third edge
  task automatic pixel_hand(input string tag, input int r, input int c, input logic bl,
                            input logic [23:0] exp_rgb);
    cycle(1'b1, r, c, bl, 1'b0, 1'b0, 20'h0);
    idle();
    idle();
    check(tag, rgb_out, exp_rgb);
    check({tag, "_valid"}, rgb_valid, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        mem[r][c] = 4'((r * 3 + c) % 16);
    mem[0][0] = 4'd3;
    mem[19][9] = 4'd9;
    mem[1][1] = 4'hf;
    mem[19][0] = 4'd5;
    tile_rd_data = 4'h0;
    vga_row = '0; vga_col = '0; flash_rows = '0;
    rst_l = 1'b0; pix_valid = 1'b0; blank = 1'b0;
    frame_start = 1'b0; flash_start = 1'b0;
    #1;
    do_reset();

    cycle(1'b1, 60, 240, 1'b0, 1'b0, 1'b0, 20'h0);
    check("tl_rd_en", tile_rd_en, 1'b1);
    check("tl_rd_row", tile_rd_row, 5'd0);
    check("tl_rd_col", tile_rd_col, 4'd0);
    idle();
    check("tl_not_yet", rgb_valid, 1'b0);
    idle();
    check("tl_rgb", rgb_out, 24'h00fdff);
    check("tl_valid", rgb_valid, 1'b1);

    cycle(1'b1, 459, 399, 1'b0, 1'b0, 1'b0, 20'h0);
    check("br_rd_row", tile_rd_row, 5'd19);
    check("br_rd_col", tile_rd_col, 4'd9);
    idle(); idle();
    check("br_rgb", rgb_out, 24'hff0000);

    cycle(1'b1, 100, 400, 1'b0, 1'b0, 1'b0, 20'h0);
    check("border_no_read", tile_rd_en, 1'b0);
    idle(); idle();
    check("border_rgb", rgb_out, 24'hffffff);
    pixel_hand("bg_405", 100, 405, 1'b0, 24'h404040);
    pixel_hand("border_top", 55, 300, 1'b0, 24'hffffff);
    pixel_hand("bg_top", 54, 300, 1'b0, 24'h404040);
    pixel_hand("border_left", 200, 239, 1'b0, 24'hffffff);
    pixel_hand("blank_pf", 60, 240, 1'b1, 24'h000000);
    pixel_hand("code_f", 80, 256, 1'b0, 24'h000000);

    // flash_start together with frame_start; second request at k=5 must be ignored
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 20'h80000);
    check("flash_busy_start", flash_busy, 1'b1);
    for (int k = 0; k < 24; k++) begin
      cycle(1'b1, 450, 250, 1'b0, 1'b0, (k == 5), (k == 5) ? 20'h00001 : 20'h0);
      cycle(1'b1, 70, 250, 1'b0, 1'b0, 1'b0, 20'h0);
      cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 20'h0);
      check("flash_row19", rgb_out, ((k / 4) % 2 == 0) ? 24'hffffff : 24'hff00ff);
      if (k == 23) check("flash_done_pulse", flash_done, 1'b1);
      else check("flash_done_quiet", flash_done, 1'b0);
      idle();
      check("flash_row0", rgb_out, 24'h00fdff);
    end
    check("flash_busy_end", flash_busy, 1'b0);
    check("flash_done_once", done_seen, 1);

    cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 20'h80000);
    repeat (5) cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 20'h0);
    cycle(1'b1, 450, 250, 1'b0, 1'b0, 1'b0, 20'h0);
    do_reset();
    idle();
    check("post_rst_bubble", rgb_valid, 1'b0);
    pixel_hand("post_rst_row19", 450, 250, 1'b0, 24'hff00ff);
    repeat (30) cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 20'h0);
    check("no_done_after_abort", done_seen, 1);

    for (int i = 0; i < 600; i++) begin
      int r, c;
      r = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 479)) : int'($urandom_range(50, 470));
      c = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 639)) : int'($urandom_range(230, 410));
      cycle($urandom_range(0, 3) != 0, r, c, $urandom_range(0, 9) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0, 20'($urandom));
    end
    repeat (3) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/playfield_renderer.md
PLAYFIELD_RENDERER -- requirements
Module: playfield_renderer

Interface
- REQ-001: Parameter FLASH_PERIOD, default 4, frames per on/off phase of line-clear flash.
- REQ-002: Parameter FLASH_TOGGLES, default 6, number of on/off phases per flash sequence.
- REQ-003: clk  in  1  single clock; all state SHALL update on its rising edge.
- REQ-004: rst_l  in  1  reset, synchronous and active-low.
- REQ-005: pix_valid  in  1  vga_row/vga_col/blank valid this cycle.
- REQ-006: vga_row  in  10  pixel row, 0..479; vga_col  in  10  pixel column, 0..639.
- REQ-007: blank  in  1  pixel outside active video.
- REQ-008: frame_start  in  1  one-cycle pulse at the start of each frame.
- REQ-009: flash_start  in  1  one-cycle request to begin a line-clear flash; flash_rows  in  20  row mask, bit r = playfield row r.
- REQ-010: tile_rd_en  out  1; tile_rd_row  out  5; tile_rd_col  out  4  tile RAM read request.
- REQ-011: tile_rd_data  in  4  tile_type_t value; valid exactly one cycle after tile_rd_en.
- REQ-012: rgb_out  out  24  pixel color; rgb_valid  out  1  rgb_out valid.
- REQ-013: flash_busy  out  1  flash in progress; flash_done  out  1  one-cycle pulse at flash end.

Function
- REQ-014: Fixed three-stage pipeline; a pixel presented with pix_valid in cycle N SHALL appear on rgb_out with rgb_valid=1 in cycle N+3; no stalls, full throughput.
- REQ-015: Stage 1 region classification (inclusive start, exclusive end): playfield = col 240..399 and row 60..459; border = col 235..404 and row 55..464 but not playfield; else background.
- REQ-016: For playfield pixels, stage 1 SHALL assert tile_rd_en with tile_rd_col = (col-240)/16 (0..9), tile_rd_row = (row-60)/20 (0..19); tile_rd_en SHALL be 0 for all other pixels and when pix_valid=0.
- REQ-017: Color map: BLANK 000000, GARBAGE aaaaaa, GHOST 808080, I 00fdff, O ffff00, T ff00ff, J 0000ff, L ff8000, S 00ff00, Z ff0000; codes 10..15 SHALL render 000000.
- REQ-018: Border pixels SHALL render ffffff; background 404040; blank=1 SHALL render 000000 regardless of region or flash.
- REQ-019: Flash FSM states IDLE, ON, OFF. IDLE: flash_start=1 latches flash_rows, clears phase and frame counters, -> ON.
- REQ-020: In ON/OFF, each frame_start increments the frame counter; on reaching FLASH_PERIOD, counter clears, phase counter increments, state toggles ON<->OFF.
- REQ-021: When phase counter reaches FLASH_TOGGLES, FSM SHALL return to IDLE and pulse flash_done for exactly one cycle in that transition cycle.
- REQ-022: In ON, playfield pixels whose row mask bit is set SHALL render ffffff irrespective of tile type; in OFF and IDLE, normal tile color.
- REQ-023: flash_busy=1 in ON and OFF, else 0.
- REQ-024: flash_start while busy SHALL be ignored; latched mask unchanged.
- REQ-025: flash_start and frame_start in same cycle in IDLE: enter ON, frame counter 0 (the frame_start is not counted).
- REQ-026: Flash row mask and state SHALL be sampled per pixel at stage 1 and carried down the pipeline, so a state change never splits a single pixel's color.
- REQ-027: pix_valid=0 bubbles SHALL propagate as rgb_valid=0 three cycles later.

Reset
- REQ-028: While rst_l=0 at a clock edge: rgb_out=000000, rgb_valid=0, tile_rd_en=0, tile_rd_row=0, tile_rd_col=0, flash_busy=0, flash_done=0, FSM=IDLE, all counters and latched mask 0, pipeline flushed.
- REQ-029: Reset mid-flash or mid-line SHALL abort with no flash_done pulse; first valid output appears 3 cycles after first pix_valid following release.

Verification
- REQ-030: row=60, col=240, pix_valid=1, tile_rd_data=I -> tile_rd_en=1, row 0, col 0 at N+1; rgb_out=00fdff, rgb_valid=1 at N+3.
- REQ-031: row=459, col=399, data=Z -> rd row 19, col 9; rgb ff0000. col=400,row=100 -> ffffff, no read; col=405 -> 404040.
- REQ-032: blank=1 on playfield pixel -> 000000; data=4'hF -> 000000.
- REQ-033: flash_start, flash_rows=20'h80000, FLASH_PERIOD=4, FLASH_TOGGLES=6: row 19 tiles ffffff for frames 0-3, normal 4-7, ...; flash_done pulses once after 24 frame_starts; flash_busy then 0.
- REQ-034: Second flash_start during flash -> ignored; rst_l=0 mid-flash -> IDLE, no flash_done.
- REQ-035: Continuous random pixel stream with bubbles -> rgb_valid matches pix_valid delayed 3, colors match reference model every cycle.
